// File: rtl/hazard_scoreboard_if.sv
// Bundle of ID/EX/MEM pipeline inputs and scoreboard status outputs for the
// load-use hazard scoreboard. The pipeline side is the master, the scoreboard
// is the slave.
interface hazard_scoreboard_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                     id_valid;
  logic [31:0]              instr_id;
  logic                     ex_valid;
  logic [31:0]              instr_ex;
  logic                     ex_advance;
  logic                     mem_resp_valid;
  logic                     stall;
  logic                     q_full;
  logic [$clog2(DEPTH):0]   q_count;
  logic [CNT_W-1:0]         stall_count;
  logic                     overflow;

  modport master (
    output id_valid, instr_id, ex_valid, instr_ex, ex_advance, mem_resp_valid,
    input  stall, q_full, q_count, stall_count, overflow
  );

  modport slave (
    input  id_valid, instr_id, ex_valid, instr_ex, ex_advance, mem_resp_valid,
    output stall, q_full, q_count, stall_count, overflow
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard for an in-order RV32 pipeline. Tracks the
// destination registers of loads in flight (FIFO, oldest at head), compares
// them and the load currently in EX against the sources of the ID
// instruction, and raises a combinational stall. Also counts stall cycles and
// flags any push attempted into a full queue.
module hazard_scoreboard #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QC_W  = $clog2(DEPTH) + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Field extraction
  logic [6:0] id_op;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [6:0] ex_op;
  logic [4:0] ex_rd;

  assign id_op  = bus.instr_id[6:0];
  assign id_rs1 = bus.instr_id[19:15];
  assign id_rs2 = bus.instr_id[24:20];
  assign ex_op  = bus.instr_ex[6:0];
  assign ex_rd  = bus.instr_ex[11:7];

  // Immediate/funct bits play no part in hazard detection.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr_id[31:25], bus.instr_id[14:7],
                               bus.instr_ex[31:12]};

  // State
  logic [4:0]       entry_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [QC_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             overflow_q, overflow_d;

  // Source-use decode of the ID instruction; x0 is never a real dependency
  logic use_rs1, use_rs2;
  logic rs1_used, rs2_used;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_op)
      OP_JALR, OP_LOAD, OP_OPIMM: use_rs1 = 1'b1;
      OP_STORE, OP_BRANCH, OP_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: ;
      default: ;
    endcase
  end

  assign rs1_used = use_rs1 && (id_rs1 != 5'd0);
  assign rs2_used = use_rs2 && (id_rs2 != 5'd0);

  // Load currently in EX and its hazard against the ID sources
  logic ex_load_rd;
  logic ex_hit;

  assign ex_load_rd = bus.ex_valid && (ex_op == OP_LOAD) && (ex_rd != 5'd0);
  assign ex_hit     = ex_load_rd &&
                      ((rs1_used && (id_rs1 == ex_rd)) ||
                       (rs2_used && (id_rs2 == ex_rd)));

  // Compare every live queue entry (head included, even while it pops)
  logic             q_hit;
  logic [PTR_W-1:0] slot_off;

  always_comb begin
    q_hit    = 1'b0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - head_q;
      if (({1'b0, slot_off} < count_q) &&
          ((rs1_used && (entry_q[i] == id_rs1)) ||
           (rs2_used && (entry_q[i] == id_rs2))))
        q_hit = 1'b1;
    end
  end

  // Queue control
  logic full;
  logic struct_hit;
  logic stall;
  logic push_req;
  logic pop;
  logic push_ok;

  assign full       = (count_q == QC_W'(DEPTH));
  assign struct_hit = full && !bus.mem_resp_valid && ex_load_rd;
  assign stall      = (bus.id_valid && (ex_hit || q_hit)) || struct_hit;
  assign push_req   = ex_load_rd && bus.ex_advance;
  assign pop        = bus.mem_resp_valid && (count_q != '0);
  assign push_ok    = push_req && (!full || pop);

  // Next-state for pointers, occupancy, stall counter and overflow flag
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    stall_cnt_d = stall_cnt_q;
    overflow_d  = overflow_q;
    if (pop)
      head_d = head_q + 1'b1;
    if (push_ok)
      tail_d = tail_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok)
      overflow_d = 1'b1;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Control registers, synchronously cleared
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Entry storage written at the tail on an accepted push
  // NOTE: storage is not reset; an entry only counts while it lies inside the
  // head..count window, and clearing count/pointers empties that window.
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      entry_q[tail_q] <= ex_rd;
  end

  assign bus.stall       = stall;
  assign bus.q_full      = full;
  assign bus.q_count     = count_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (DEPTH=4, CNT_W=4).
module tb_hazard_scoreboard;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_scoreboard_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic idv, input logic [31:0] id, input logic exv,
                       input logic [31:0] ex, input logic adv, input logic resp);
    bus.id_valid       = idv;
    bus.instr_id       = id;
    bus.ex_valid       = exv;
    bus.instr_ex       = ex;
    bus.ex_advance     = adv;
    bus.mem_resp_valid = resp;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_q_count", 32'(bus.q_count), 0);
    check("rst_q_full", 32'(bus.q_full), 0);
    check("rst_stall_count", 32'(bus.stall_count), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_stall", 32'(bus.stall), 0);

    // Load in EX vs dependent / independent ID instruction
    drive(1'b1, enc_add(5'd6, 5'd5, 5'd7), 1'b1, enc_lw(5'd5, 5'd1), 1'b0, 1'b0);
    check("ex_hit_dep", 32'(bus.stall), 1);
    drive(1'b1, enc_add(5'd6, 5'd8, 5'd9), 1'b1, enc_lw(5'd5, 5'd1), 1'b0, 1'b0);
    check("ex_hit_indep", 32'(bus.stall), 0);
    drive(1'b0, enc_add(5'd6, 5'd5, 5'd7), 1'b1, enc_lw(5'd5, 5'd1), 1'b0, 1'b0);
    check("ex_hit_id_invalid", 32'(bus.stall), 0);

    // lw x0 never creates a hazard nor a queue entry
    drive(1'b1, enc_add(5'd6, 5'd0, 5'd0), 1'b1, enc_lw(5'd0, 5'd2), 1'b1, 1'b0);
    check("x0_stall", 32'(bus.stall), 0);
    tick();
    check("x0_no_push", 32'(bus.q_count), 0);

    // Push x3, x4
    drive(1'b0, 32'd0, 1'b1, enc_lw(5'd3, 5'd1), 1'b1, 1'b0);
    tick();
    check("push1_count", 32'(bus.q_count), 1);
    drive(1'b0, 32'd0, 1'b1, enc_lw(5'd4, 5'd1), 1'b1, 1'b0);
    tick();
    check("push2_count", 32'(bus.q_count), 2);
    drive(1'b1, enc_lui(5'd3), 1'b0, 32'd0, 1'b0, 1'b0);
    check("lui_no_src", 32'(bus.stall), 0);
    drive(1'b1, enc_sw(5'd1, 5'd4), 1'b0, 32'd0, 1'b0, 1'b0);
    check("sw_rs1_q_hit", 32'(bus.stall), 1);
    drive(1'b1, enc_sw(5'd4, 5'd1), 1'b0, 32'd0, 1'b0, 1'b0);
    check("sw_rs2_q_hit", 32'(bus.stall), 1);
    // Head still counts while it is being popped
    drive(1'b1, enc_add(5'd1, 5'd3, 5'd0), 1'b0, 32'd0, 1'b0, 1'b1);
    check("pop_no_bypass", 32'(bus.stall), 1);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    check("pop1_count", 32'(bus.q_count), 1);
    drive(1'b1, enc_add(5'd1, 5'd3, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0);
    check("x3_popped", 32'(bus.stall), 0);
    drive(1'b1, enc_add(5'd1, 5'd4, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0);
    check("x4_still_live", 32'(bus.stall), 1);

    // Fill to DEPTH: x4, x11, x12, x13
    for (int r = 11; r <= 13; r++) begin
      drive(1'b0, 32'd0, 1'b1, enc_lw(5'(r), 5'd1), 1'b1, 1'b0);
      tick();
    end
    check("fill_count", 32'(bus.q_count), 4);
    check("fill_full", 32'(bus.q_full), 1);
    drive(1'b0, 32'd0, 1'b1, enc_lw(5'd10, 5'd1), 1'b0, 1'b0);
    check("struct_no_resp", 32'(bus.stall), 1);
    drive(1'b0, 32'd0, 1'b1, enc_lw(5'd10, 5'd1), 1'b0, 1'b1);
    check("struct_with_resp", 32'(bus.stall), 0);
    drive(1'b1, enc_add(5'd1, 5'd4, 5'd0), 1'b1, enc_lw(5'd10, 5'd1), 1'b0, 1'b1);
    check("resp_but_src_hit", 32'(bus.stall), 1);
    // Simultaneous push x10 / pop x4 while full
    drive(1'b0, 32'd0, 1'b1, enc_lw(5'd10, 5'd1), 1'b1, 1'b1);
    tick();
    check("pushpop_count", 32'(bus.q_count), 4);
    check("pushpop_overflow", 32'(bus.overflow), 0);
    check("pushpop_stall_count", 32'(bus.stall_count), 0);
    drive(1'b1, enc_add(5'd1, 5'd4, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0);
    check("x4_gone", 32'(bus.stall), 0);
    drive(1'b1, enc_add(5'd1, 5'd0, 5'd10), 1'b0, 32'd0, 1'b0, 1'b0);
    check("x10_tail", 32'(bus.stall), 1);

    // Forced push while full without pop: one struct stall cycle, dropped push
    drive(1'b0, 32'd0, 1'b1, enc_lw(5'd20, 5'd1), 1'b1, 1'b0);
    tick();
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.q_count), 4);
    check("ovf_stall_count", 32'(bus.stall_count), 1);
    drive(1'b1, enc_add(5'd1, 5'd20, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0);
    check("ovf_x20_absent", 32'(bus.stall), 0);
    drive(1'b1, enc_add(5'd1, 5'd11, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0);
    check("ovf_x11_head", 32'(bus.stall), 1);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, enc_add(5'd1, 5'd11, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0);
    check("drain_x11_gone", 32'(bus.stall), 0);
    drive(1'b1, enc_add(5'd1, 5'd12, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0);
    check("drain_x12_live", 32'(bus.stall), 1);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    repeat (3) tick();
    check("drain_empty", 32'(bus.q_count), 0);
    tick();
    check("empty_pop_count", 32'(bus.q_count), 0);
    check("empty_pop_overflow", 32'(bus.overflow), 1);
    idle();

    // Saturating stall counter: 20 more stall cycles from 1
    drive(1'b1, enc_add(5'd1, 5'd5, 5'd0), 1'b1, enc_lw(5'd5, 5'd1), 1'b0, 1'b0);
    repeat (13) tick();
    check("sc_before_sat", 32'(bus.stall_count), 14);
    repeat (7) tick();
    check("sc_saturated", 32'(bus.stall_count), 15);

    // Reset mid-stall with a push active
    drive(1'b1, enc_add(5'd1, 5'd5, 5'd0), 1'b1, enc_lw(5'd5, 5'd1), 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check("rst2_q_count", 32'(bus.q_count), 0);
    check("rst2_stall_count", 32'(bus.stall_count), 0);
    check("rst2_overflow", 32'(bus.overflow), 0);
    check("rst2_q_full", 32'(bus.q_full), 0);
    rst = 1'b0;
    idle();
    check("rst2_stall", 32'(bus.stall), 0);
    drive(1'b1, enc_add(5'd1, 5'd5, 5'd0), 1'b0, 32'd0, 1'b0, 1'b0);
    check("rst2_no_push", 32'(bus.stall), 0);
    drive(1'b1, enc_add(5'd1, 5'd7, 5'd5), 1'b1, enc_lw(5'd5, 5'd1), 1'b0, 1'b0);
    check("rst2_ex_hit_only", 32'(bus.stall), 1);
    idle();
    tick();
    check("end_stall_count", 32'(bus.stall_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning max outstanding loads tracked (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning stall counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port id_valid  input  1  instr_id holds a real instruction.
REQ-006 SHALL have port instr_id  input  32  RV32 instruction in ID.
REQ-007 SHALL have port ex_valid  input  1  instr_ex holds a real instruction.
REQ-008 SHALL have port instr_ex  input  32  RV32 instruction in EX.
REQ-009 SHALL have port ex_advance  input  1  EX instruction moves to MEM this cycle.
REQ-010 SHALL have port mem_resp_valid  input  1  oldest outstanding load writes back this cycle.
REQ-011 SHALL have port stall  output  1  hold IF/ID, bubble EX.
REQ-012 SHALL have port q_full  output  1  DEPTH loads outstanding.
REQ-013 SHALL have port q_count  output  $clog2(DEPTH)+1  loads outstanding.
REQ-014 SHALL have port stall_count  output  CNT_W  saturating count of stall cycles.
REQ-015 SHALL have port overflow  output  1  sticky illegal-push flag.

Function
REQ-016 SHALL decode source use from instr_id[6:0]: LUI/AUIPC/JAL none; JALR/LOAD/OP-IMM rs1 only; STORE/BRANCH/OP rs1 and rs2; other opcodes none.
REQ-017 SHALL ignore any source or destination equal to x0.
REQ-018 SHALL flag ex_hit when ex_valid, instr_ex[6:0]=0000011, and instr_ex[11:7] matches a used ID source.
REQ-019 SHALL flag q_hit when any valid queue entry matches a used ID source, including the head entry being popped this cycle (no same-cycle writeback bypass).
REQ-020 SHALL flag struct_hit when q_full, mem_resp_valid=0, and EX holds a valid load with rd!=0.
REQ-021 SHALL drive stall = id_valid & (ex_hit | q_hit) | struct_hit, purely combinational, zero latency.
REQ-022 SHALL push instr_ex[11:7] at queue tail when ex_valid & ex_advance & EX is load & rd!=0.
REQ-023 SHALL pop queue head when mem_resp_valid and q_count>0; mem_resp_valid with empty queue SHALL be ignored.
REQ-024 SHALL allow simultaneous push and pop, including when full; q_count unchanged.
REQ-025 SHALL, on push while full without pop, drop the push, leave queue unchanged, set overflow=1 until reset.
REQ-026 SHALL wrap head/tail pointers modulo DEPTH; q_count range 0..DEPTH.
REQ-027 SHALL assert q_full exactly when q_count==DEPTH.
REQ-028 SHALL increment stall_count each cycle stall=1, saturating at 2^CNT_W-1.

Reset
REQ-029 SHALL on rst=1 at a clock edge clear queue, pointers, q_count, stall_count, overflow to 0, regardless of concurrent push/pop.
REQ-030 SHALL with queue empty after reset drive stall from ex_hit only; q_full=0.

Verification
REQ-031 SHALL cover: EX lw x5; ID add x6,x5,x7 -> stall=1 same cycle; ID add x6,x8,x9 -> stall=0.
REQ-032 SHALL cover: lw x0 in EX, ID uses x0 -> stall=0, no push, q_count=0.
REQ-033 SHALL cover: push x3, x4 (q_count=2), ID lui x3 -> stall=0; ID sw x1,0(x4) -> stall=1; one mem_resp_valid -> x3 popped, ID add x1,x3,x0 -> stall=0 next cycle.
REQ-034 SHALL cover: DEPTH=4 filled (q_full=1), EX lw x10, no resp -> stall=1; same with resp -> stall=0 only if no source hit, q_count stays 4.
REQ-035 SHALL cover: forced push while full without pop -> overflow=1, q_count=4, contents unchanged; mem_resp_valid with q_count=0 -> no change.
REQ-036 SHALL cover: CNT_W=4, 20 stall cycles -> stall_count=15; rst mid-stall with push active -> all outputs 0 next cycle.
